ofifo: RTL and testbench
========================

Name: ofifo

Overview:
- Output collector directly south of the mac_tile array.
- Captures the skewed per-column partial sums leaving each column's out_s, one independent circular FIFO per column.
- Presents a full aligned row, one psum per column, to the downstream SRAM writer once every column holds data.
- Absorbs the column-to-column skew of the systolic wavefront.

Parameters:
- col, 8, number of array columns (one FIFO each)
- psum_bw, 16, psum width; matches the mac_tile psum width
- depth, 64, entries per column FIFO; must be a power of 2, at least 2

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- in  input  col*psum_bw  column psums; column k occupies bits [(k+1)*psum_bw-1 : k*psum_bw]
- wr  input  col  per-column write strobe (valid of that column's out_s)
- rd  input  1  pop one aligned row
- out  output  col*psum_bw  head row, same packing as in
- o_valid  output  1  every column non-empty
- o_full  output  1  any column full
- o_ready  output  1  no column full (equals ~o_full)
- o_overflow  output  1  sticky: a write hit a full column

Behaviour:
- Reset (reset==0, asynchronous): all read/write pointers = 0; o_overflow = 0; o_valid = 0; o_full = 0; o_ready = 1.
- Memory contents are not reset; out is don't-care while o_valid = 0.
- Pointers are log2(depth)+1 bits, with the MSB as the wrap bit.
- empty_k = (wptr_k == rptr_k).
- full_k = (index bits equal) and (wrap bits differ).
- Write, column k, at posedge with wr[k]==1 and !full_k: mem_k[wptr_k] <= in slice k; wptr_k increments and wraps mod 2*depth.
- Write with wr[k]==1 and full_k: data dropped, wptr_k unchanged, o_overflow <= 1. o_overflow clears only on reset.
- Read is show-ahead: out slice k = mem_k[rptr_k] combinationally. Data written at edge N is visible at out from edge N onward, once o_valid rises.
- Pop: at posedge with rd==1 and o_valid==1, every rptr_k increments together.
- rd while o_valid==0: ignored; no pointer moves; no error flag.
- Simultaneous wr[k] and rd on a full column: the write is checked against full_k sampled before the edge, so it is dropped and o_overflow sets. The pop still occurs.
- Simultaneous wr[k] and rd on a column with exactly 1 entry: both occur; occupancy stays 1.
- o_valid = AND over k of !empty_k. o_full = OR over k of full_k. Both are combinational from the pointers, so there is no registered latency.
- Each column's occupancy is independent; skewed writes are expected.
- Reset asserted mid-stream discards all queued data immediately.
- No arithmetic on data; psums pass through unmodified, except under the optional feature.

Optional Feature:
- Macro: OFIFO_RELU_EN.
- Defined: each out slice is treated as two's-complement. A slice with MSB=1 is driven as 0; otherwise it passes unchanged. Stored data is unaffected. Applied on the read path only.
- Not defined: out is the raw stored psum.

Decomposition:
- Shared package holds:
  - the default array dimension (col=8);
  - PSUM_BW=16 and BW=4, shared with mac_tile and mac;
  - the OFIFO_DEPTH default;
  - the pointer-width function clog2(depth)+1.
- One natural sub-module: ofifo_col_fifo. It is a single-column psum_bw x depth show-ahead FIFO with wr, rd, empty, full and dout. ofifo instantiates col copies via generate, ANDs the empties, ORs the fulls, and broadcasts rd gated by o_valid.

Test Plan:
- Reset then idle → o_valid=0, o_full=0, o_ready=1, o_overflow=0. Pulse rd with no writes → pointers unchanged; a later single row write gives o_valid=1.
- Skewed fill: column k is written with value 16'h0100+k at cycle k, for k=0..7 → o_valid stays 0 until the cycle after column 7 is written. Then out = {16'h0107,...,16'h0100}; rd pops → o_valid=0.
- Fill all columns with depth=64 rows (values = row index) → o_full=1, o_ready=0. A 65th write to column 3 → o_overflow=1 and data dropped. Draining 64 rows returns 0..63 in order.
- Wrap-around: 100 cycles of continuous write-all plus rd-when-valid → out sequence is strictly in order; o_full never asserts; occupancy holds at 1.
- Assert reset asynchronously mid-clock with 10 rows queued → o_valid falls immediately, without waiting for an edge. After release, writing row 16'hABCD gives out=16'hABCD on all columns.
- With OFIFO_RELU_EN defined: write 16'hFFF0 to col0 and 16'h0010 to col1 → out col0=16'h0000, col1=16'h0010. Without the macro, col0=16'hFFF0.

Source files
------------

// File: rtl/ofifo_pkg.sv
// Shared dimensions for the mac_tile array and its south-side output collector.
package ofifo_pkg;

    localparam int COL         = 8;
    localparam int PSUM_BW     = 16;
    localparam int BW          = 4;
    localparam int OFIFO_DEPTH = 64;

    // Pointer carries one extra wrap bit above the index bits.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ofifo_col_fifo.sv
// Single-column show-ahead circular FIFO; head entry is always driven on dout.
module ofifo_col_fifo
    import ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [psum_bw-1:0] din,
    input  logic               wr,
    input  logic               rd,
    output logic               empty,
    output logic               full,
    output logic [psum_bw-1:0] dout
);

    localparam int PW = ptr_w(depth);
    localparam int AW = PW - 1;

    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic [psum_bw-1:0] mem [depth];
    logic               do_wr;
    logic               do_rd;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ofifo.sv
// Per-column psum collector that presents aligned rows once every column holds data.
// Optional macro OFIFO_RELU_EN clamps negative psums to zero on the read path.
module ofifo
    import ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);

    logic [col-1:0]     empty;
    logic [col-1:0]     full;
    logic [psum_bw-1:0] col_dout [col];
    logic               pop;

`ifdef OFIFO_RELU_EN
    function automatic logic [psum_bw-1:0] relu(input logic signed [psum_bw-1:0] v);
        if (v < 0) return '0;
        return v;
    endfunction
`endif

    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    // A pop advances every column together, and only when a full row exists.
    assign pop     = rd && o_valid;

    for (genvar k = 0; k < col; k++) begin : g_col
        ofifo_col_fifo #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_col (
            .clk   (clk),
            .reset (reset),
            .din   (in[k*psum_bw +: psum_bw]),
            .wr    (wr[k]),
            .rd    (pop),
            .empty (empty[k]),
            .full  (full[k]),
            .dout  (col_dout[k])
        );
`ifdef OFIFO_RELU_EN
        assign out[k*psum_bw +: psum_bw] = relu(col_dout[k]);
`else
        assign out[k*psum_bw +: psum_bw] = col_dout[k];
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)             o_overflow <= 1'b0;
        else if (|(wr & full))  o_overflow <= 1'b1;
    end

endmodule

// File: tb/tb_ofifo.sv
// Scoreboard bench for ofifo: per-column queue model, expected rows checked by a negedge monitor.
module tb_ofifo;

    localparam int NC = 8;
    localparam int PB = 16;
    localparam int DP = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NC*PB-1:0] in = '0;
    logic [NC-1:0]    wr = '0;
    logic             rd = 1'b0;
    logic [NC*PB-1:0] out;
    logic             o_valid, o_full, o_ready, o_overflow;

    ofifo #(.col(NC), .psum_bw(PB), .depth(DP)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .wr         (wr),
        .rd         (rd),
        .out        (out),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_ready    (o_ready),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    logic [PB-1:0]    mq [NC][$];
    logic [NC*PB-1:0] exp_q [$];
    logic             ovf_m = 1'b0;
    int               n_cmp = 0;
    int               n_bad = 0;

    function automatic logic [PB-1:0] exp_slice(input logic [PB-1:0] v);
`ifdef OFIFO_RELU_EN
        if (v[PB-1]) return '0;
`endif
        return v;
    endfunction

    function automatic logic m_valid();
        for (int k = 0; k < NC; k++) if (mq[k].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int k = 0; k < NC; k++) if (mq[k].size() == DP) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cmp(input string name, input logic [NC*PB-1:0] act, input logic [NC*PB-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_flags();
        cmp("o_valid", {{(NC*PB-1){1'b0}}, o_valid}, {{(NC*PB-1){1'b0}}, m_valid()});
        cmp("o_full", {{(NC*PB-1){1'b0}}, o_full}, {{(NC*PB-1){1'b0}}, m_full()});
        cmp("o_ready", {{(NC*PB-1){1'b0}}, o_ready}, {{(NC*PB-1){1'b0}}, !m_full()});
        cmp("o_overflow", {{(NC*PB-1){1'b0}}, o_overflow}, {{(NC*PB-1){1'b0}}, ovf_m});
    endtask

    // Called just after a posedge; applies one cycle of stimulus and advances the model.
    task automatic drive(input logic [NC-1:0] w, input logic [NC*PB-1:0] d, input logic r);
        logic [NC-1:0]    acc;
        logic [NC*PB-1:0] row;
        wr = w; in = d; rd = r;
        for (int k = 0; k < NC; k++) begin
            acc[k] = w[k] && (mq[k].size() < DP);
            if (w[k] && !acc[k]) ovf_m = 1'b1;
        end
        if (r && m_valid()) begin
            for (int k = 0; k < NC; k++) row[k*PB +: PB] = exp_slice(mq[k].pop_front());
            exp_q.push_back(row);
        end
        for (int k = 0; k < NC; k++) if (acc[k]) mq[k].push_back(d[k*PB +: PB]);
        @(posedge clk);
        #1;
        wr = '0; rd = 1'b0;
        check_flags();
    endtask

    function automatic logic [NC*PB-1:0] splat(input logic [PB-1:0] v);
        return {NC{v}};
    endfunction

    function automatic logic [NC*PB-1:0] rnd_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) mq[k].delete();
        exp_q.delete();
        ovf_m = 1'b0;
    endtask

    // Monitor: every accepted pop must match the oldest expected row.
    always @(negedge clk) begin
        if (reset && rd && o_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: DUT popped row %h with no expected row at %0t", out, $time);
            end else begin
                cmp("row_data", out, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [NC*PB-1:0] row;
        int               r_ctl;

        // Reset state
        #2;
        check_flags();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_flags();

        // Pop with nothing queued is ignored; then one full row becomes visible
        drive('0, '0, 1'b1);
        drive('1, splat(16'h5A5A), 1'b0);
        drive('0, '0, 1'b1);

        // Skewed wavefront fill
        for (int k = 0; k < NC; k++) begin
            row = '0;
            row[k*PB +: PB] = 16'h0100 + PB'(k);
            drive(NC'(1) << k, row, 1'b0);
        end
        drive('0, '0, 1'b1);

        // Fill to full, overflow column 3, then drain in order
        for (int i = 0; i < DP; i++) drive('1, splat(PB'(i)), 1'b0);
        drive(NC'(8), splat(16'hDEAD), 1'b0);
        for (int i = 0; i < DP; i++) drive('0, '0, 1'b1);

        // Full with simultaneous write and pop: write dropped, pop happens
        for (int i = 0; i < DP; i++) drive('1, rnd_row(), 1'b0);
        drive('1, rnd_row(), 1'b1);
        for (int i = 0; i < DP; i++) drive('0, '0, 1'b1);

        // Streaming wrap-around at occupancy one
        for (int i = 0; i < 100; i++) drive('1, rnd_row(), m_valid());
        drive('0, '0, 1'b1);

        // Random skewed traffic
        for (int i = 0; i < 400; i++) begin
            r_ctl = int'($urandom_range(0, 3));
            drive(NC'($urandom), rnd_row(), r_ctl != 0);
        end
        while (m_valid()) drive('0, '0, 1'b1);

        // Asynchronous reset with rows queued
        for (int i = 0; i < 10; i++) drive('1, rnd_row(), 1'b0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_flags();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_flags();
        drive('1, splat(16'hABCD), 1'b0);
        cmp("row_after_reset", out, splat(exp_slice(16'hABCD)));
        drive('0, '0, 1'b1);

        // Sign handling on the read path
        row = splat(16'h1234);
        row[0 +: PB]  = 16'hFFF0;
        row[PB +: PB] = 16'h0010;
        drive('1, row, 1'b0);
        drive('0, '0, 1'b1);

        @(posedge clk);
        #1;
        cmp("exp_q_drained", {{(NC*PB-32){1'b0}}, 32'(exp_q.size())}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
